// File: rtl/reg_scoreboard_ctrl_if.sv
// Issue/writeback/status bundle between the issue stage and the register scoreboard.
interface reg_scoreboard_ctrl_if #(
    parameter int REG_W = 3
);
    logic                    i_issue_valid;
    logic                    i_dest_flag;
    logic [REG_W-1:0]        i_dest;
    logic                    i_src_a_flag;
    logic [REG_W-1:0]        i_src_a;
    logic                    i_src_b_flag;
    logic [REG_W-1:0]        i_src_b;
    logic                    i_halt;
    logic                    i_wb_valid;
    logic [REG_W-1:0]        i_wb_dest;
    logic                    i_flush;
    logic                    o_stall;
    logic                    o_issue_fire;
    logic [(1<<REG_W)-1:0]   o_busy_mask;
    logic                    o_halted;
    logic                    o_err;

    modport master (
        output i_issue_valid, i_dest_flag, i_dest, i_src_a_flag, i_src_a,
               i_src_b_flag, i_src_b, i_halt, i_wb_valid, i_wb_dest, i_flush,
        input  o_stall, o_issue_fire, o_busy_mask, o_halted, o_err
    );

    modport slave (
        input  i_issue_valid, i_dest_flag, i_dest, i_src_a_flag, i_src_a,
               i_src_b_flag, i_src_b, i_halt, i_wb_valid, i_wb_dest, i_flush,
        output o_stall, o_issue_fire, o_busy_mask, o_halted, o_err
    );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Issue-stage register scoreboard: per-register pending-write counters, RAW/WAW/saturation
// stalls, and HALT drain sequencing (RUN -> DRAIN -> HALTED).
module reg_scoreboard_ctrl #(
    parameter int REG_W     = 3,
    parameter int CNT_W     = 2,
    parameter bit WAW_CHECK = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    reg_scoreboard_ctrl_if.slave sb
);
    localparam int unsigned NREG = 1 << REG_W;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  busy;
    logic             err, err_set;
    logic             dest_en, raw, waw, sat, stall, fire;
    logic             inc, dec, nxt_zero;

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // HALT carries no destination, so its dest flag never reaches the hazard or counter logic.
    always_comb begin
        dest_en = sb.i_dest_flag & ~sb.i_halt;
        raw     = (sb.i_src_a_flag & busy[sb.i_src_a]) | (sb.i_src_b_flag & busy[sb.i_src_b]);
        waw     = WAW_CHECK & dest_en & busy[sb.i_dest];
        sat     = dest_en & (cnt[sb.i_dest] == '1);
        stall   = sb.i_issue_valid & (raw | waw | sat | (state != S_RUN));
        fire    = sb.i_issue_valid & ~stall & ~sb.i_flush;
        err_set = sb.i_wb_valid & ~busy[sb.i_wb_dest] & ~sb.i_flush;
    end

    always_comb begin
        nxt_zero = 1'b1;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc        = fire & dest_en & (sb.i_dest == REG_W'(r));
            dec        = sb.i_wb_valid & busy[r] & (sb.i_wb_dest == REG_W'(r));
            cnt_nxt[r] = cnt[r];
            if (sb.i_flush) begin
                cnt_nxt[r] = '0;
            end else if (inc & ~dec) begin
                cnt_nxt[r] = cnt[r] + CNT_W'(1);
            end else if (dec & ~inc) begin
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
            nxt_zero = nxt_zero & (cnt_nxt[r] == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (fire & sb.i_halt) state_nxt = S_DRAIN;
            S_DRAIN:  if (nxt_zero)         state_nxt = S_HALTED;
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_RUN;
            err   <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            state <= state_nxt;
            err   <= err | err_set;
            cnt   <= cnt_nxt;
        end
    end

    assign sb.o_stall      = stall;
    assign sb.o_issue_fire = fire;
    assign sb.o_busy_mask  = busy;
    assign sb.o_halted     = (state == S_HALTED);
    assign sb.o_err        = err;
endmodule
